// File: rtl/axis_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_gate_pkg
// Purpose  : Shared types and constants for the credit-driven AXI-Stream
//            frame gate (axis_credit_gate) and its helpers.
// Contents : state_t        - gate FSM states
//            MIN_MAX_BEATS  - smallest meaningful truncation length
//            beat_cnt_width - width of the per-frame beat counter
// Revision : 1.0 - initial release
// ============================================================================
package axis_gate_pkg;

    // TRUNC is only reachable when AXIS_GATE_TRUNC_EN is defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DROP  = 2'd2,
        TRUNC = 2'd3
    } state_t;

    // The first beat is never a truncation point, so a frame limit below two
    // beats has no useful meaning.
    localparam int MIN_MAX_BEATS = 2;

    function automatic int beat_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_buffer
// Purpose  : Registered AXI-Stream stage between the gate's inner interface
//            and the master port. One cycle of latency, full throughput
//            while m_tready_i is high.
//            GREEDY=0 : single output register, ready = slot free or draining.
//            GREEDY=1 : output register plus skid register, ready is purely
//                       registered (not full), so upstream timing does not
//                       depend on m_tready_i.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            s_t{data,last,valid}  upstream beat in, s_tready_o back
//            m_t{data,last,valid}  downstream beat out (registered)
//            m_tready_i            downstream ready
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
    parameter int GREEDY      = 0,
    parameter int AXIS_DWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AXIS_DWIDTH-1:0] s_tdata_i,
    input  logic                   s_tlast_i,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    output logic [AXIS_DWIDTH-1:0] m_tdata_o,
    output logic                   m_tlast_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i
);

    logic [AXIS_DWIDTH-1:0] out_data_q;
    logic                   out_last_q;
    logic                   out_valid_q;
    logic                   w_out_free;

    // Output slot can take a new beat when empty or being drained this cycle.
    assign w_out_free = ~out_valid_q | m_tready_i;

    assign m_tdata_o  = out_data_q;
    assign m_tlast_o  = out_last_q;
    assign m_tvalid_o = out_valid_q;

    generate
        if (GREEDY != 0) begin : g_skid
            logic [AXIS_DWIDTH-1:0] skid_data_q;
            logic                   skid_last_q;
            logic                   skid_valid_q;

            assign s_tready_o = ~skid_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_data_q   <= '0;
                    out_last_q   <= 1'b0;
                    out_valid_q  <= 1'b0;
                    skid_data_q  <= '0;
                    skid_last_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else if (w_out_free) begin
                    if (skid_valid_q) begin
                        // Parked beat goes first to preserve ordering.
                        out_data_q   <= skid_data_q;
                        out_last_q   <= skid_last_q;
                        out_valid_q  <= 1'b1;
                        skid_valid_q <= 1'b0;
                    end else if (s_tvalid_i) begin
                        out_data_q  <= s_tdata_i;
                        out_last_q  <= s_tlast_i;
                        out_valid_q <= 1'b1;
                    end else begin
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end else if (s_tvalid_i && !skid_valid_q) begin
                    // Output stalled but we already advertised ready: park it.
                    skid_data_q  <= s_tdata_i;
                    skid_last_q  <= s_tlast_i;
                    skid_valid_q <= 1'b1;
                end
            end
        end else begin : g_pipe
            assign s_tready_o = w_out_free;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_data_q  <= '0;
                    out_last_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end else if (w_out_free) begin
                    if (s_tvalid_i) begin
                        out_data_q  <= s_tdata_i;
                        out_last_q  <= s_tlast_i;
                        out_valid_q <= 1'b1;
                    end else begin
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_credit_gate.sv
`default_nettype none
// ============================================================================
// Module   : axis_credit_gate
// Purpose  : Credit-driven AXI-Stream frame gate. Each frame is passed or
//            dropped as a whole, decided on its first beat: it passes when a
//            credit is available (and, unless GREEDY, the inner path is
//            ready). A passed frame consumes one credit. Pass/drop/truncate
//            statistics are kept in wrapping counters.
// Macro    : AXIS_GATE_TRUNC_EN - enables max-length truncation: beat
//            MAX_BEATS of a forwarded frame is sent with tlast forced and the
//            remainder of the frame is discarded. Undefined: frames of any
//            length pass unmodified and count_trunc_o is 0.
// Ports    : clk, rst_n                clock, asynchronous active-low reset
//            credit_add_i/clear_i      credit pulses; credits_o current count
//            count_{pass,drop,trunc}_o statistics; count_clear_i zeroes them
//            s_t{data,last,valid,ready} slave stream
//            m_t{data,last,valid,ready} master stream (via axis_skid_buffer)
// Revision : 1.0 - initial release
// ============================================================================
module axis_credit_gate
    import axis_gate_pkg::*;
#(
    parameter int CFG_DWIDTH   = 8,
    parameter int CREDIT_WIDTH = 4,
    parameter int GREEDY       = 0,
    parameter int MAX_BEATS    = 256,
    parameter int AXIS_DWIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    credit_add_i,
    input  logic                    credit_clear_i,
    output logic [CREDIT_WIDTH-1:0] credits_o,
    output logic [CFG_DWIDTH-1:0]   count_pass_o,
    output logic [CFG_DWIDTH-1:0]   count_drop_o,
    output logic [CFG_DWIDTH-1:0]   count_trunc_o,
    input  logic                    count_clear_i,
    input  logic [AXIS_DWIDTH-1:0]  s_tdata_i,
    input  logic                    s_tlast_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    output logic [AXIS_DWIDTH-1:0]  m_tdata_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i
);

    localparam int                      c_max_beats  = (MAX_BEATS < MIN_MAX_BEATS) ? MIN_MAX_BEATS : MAX_BEATS;
    localparam logic [CREDIT_WIDTH-1:0] c_credit_max = {CREDIT_WIDTH{1'b1}};
    localparam logic [CREDIT_WIDTH-1:0] c_credit_one = 1;
    localparam logic [CFG_DWIDTH-1:0]   c_cnt_one    = 1;

    state_t                  state_q;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [CFG_DWIDTH-1:0]   cnt_pass_q, cnt_pass_d;
    logic [CFG_DWIDTH-1:0]   cnt_drop_q, cnt_drop_d;
    logic [CFG_DWIDTH-1:0]   cnt_trunc_q, cnt_trunc_d;

    logic [AXIS_DWIDTH-1:0]  w_inner_tdata;
    logic                    w_inner_tlast;
    logic                    w_inner_tvalid;
    logic                    w_inner_tready;

    logic                    w_pass;
    logic                    w_s_tready;
    logic                    w_s_hs;
    logic                    w_trunc_now;
    logic                    w_inc_pass;
    logic                    w_inc_drop;
    logic                    w_inc_trunc;

    // ------------------------------------------------------------------
    // Truncation point detection
    // ------------------------------------------------------------------
`ifdef AXIS_GATE_TRUNC_EN
    localparam int c_beat_w = beat_cnt_width(c_max_beats);

    logic [c_beat_w-1:0] beat_cnt_q;

    // beat_cnt_q counts beats already forwarded, so the beat now presented
    // in PASS is number beat_cnt_q+1 of the frame.
    assign w_trunc_now = (state_q == PASS) && !s_tlast_i &&
                         (beat_cnt_q == c_beat_w'(c_max_beats - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (w_s_hs) begin
            if (state_q == IDLE) begin
                beat_cnt_q <= c_beat_w'(1);
            end else if (state_q == PASS) begin
                beat_cnt_q <= beat_cnt_q + c_beat_w'(1);
            end
        end
    end
`else
    logic [31:0] w_unused_max_beats;

    assign w_unused_max_beats = 32'(c_max_beats);
    assign w_trunc_now        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Slave/inner steering
    // ------------------------------------------------------------------
    assign w_pass = (credits_q != '0) && ((GREEDY != 0) || w_inner_tready);

    always_comb begin
        w_inner_tdata  = s_tdata_i;
        w_inner_tlast  = 1'b0;
        w_inner_tvalid = 1'b0;
        w_s_tready     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_pass) begin
                    w_inner_tvalid = s_tvalid_i;
                    w_inner_tlast  = s_tvalid_i & s_tlast_i;
                    w_s_tready     = w_inner_tready;
                end else begin
                    w_s_tready = 1'b1;
                end
            end
            PASS: begin
                w_inner_tvalid = s_tvalid_i;
                w_inner_tlast  = s_tvalid_i & (s_tlast_i | w_trunc_now);
                w_s_tready     = w_inner_tready;
            end
            DROP, TRUNC: begin
                w_s_tready = 1'b1;
            end
            default: begin
                w_s_tready = 1'b0;
            end
        endcase
    end

    assign w_s_hs      = s_tvalid_i & w_s_tready;
    assign s_tready_o  = w_s_tready & rst_n;

    assign w_inc_pass  = (state_q == IDLE) && w_s_hs &&  w_pass;
    assign w_inc_drop  = (state_q == IDLE) && w_s_hs && !w_pass;
    assign w_inc_trunc = w_s_hs && w_trunc_now;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_s_hs && !s_tlast_i) begin
                        state_q <= w_pass ? PASS : DROP;
                    end
                end
                PASS: begin
                    if (w_s_hs) begin
                        if (s_tlast_i) begin
                            state_q <= IDLE;
                        end else if (w_trunc_now) begin
                            state_q <= TRUNC;
                        end
                    end
                end
                DROP, TRUNC: begin
                    if (w_s_hs && s_tlast_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Credits and statistics
    // ------------------------------------------------------------------
    always_comb begin
        credits_d = credits_q;
        if (credit_clear_i) begin
            credits_d = '0;
        end else if (credit_add_i && !w_inc_pass) begin
            if (credits_q != c_credit_max) begin
                credits_d = credits_q + c_credit_one;
            end
        end else if (w_inc_pass && !credit_add_i) begin
            credits_d = credits_q - c_credit_one;
        end
        // add together with consume leaves the count unchanged

        cnt_pass_d  = cnt_pass_q  + (w_inc_pass  ? c_cnt_one : '0);
        cnt_drop_d  = cnt_drop_q  + (w_inc_drop  ? c_cnt_one : '0);
        cnt_trunc_d = cnt_trunc_q + (w_inc_trunc ? c_cnt_one : '0);
        if (count_clear_i) begin
            cnt_pass_d  = '0;
            cnt_drop_d  = '0;
            cnt_trunc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q   <= '0;
            cnt_pass_q  <= '0;
            cnt_drop_q  <= '0;
            cnt_trunc_q <= '0;
        end else begin
            credits_q   <= credits_d;
            cnt_pass_q  <= cnt_pass_d;
            cnt_drop_q  <= cnt_drop_d;
            cnt_trunc_q <= cnt_trunc_d;
        end
    end

    assign credits_o     = credits_q;
    assign count_pass_o  = cnt_pass_q;
    assign count_drop_o  = cnt_drop_q;
    assign count_trunc_o = cnt_trunc_q;

    // ------------------------------------------------------------------
    // Inner -> master register stage
    // ------------------------------------------------------------------
    axis_skid_buffer #(
        .GREEDY      (GREEDY),
        .AXIS_DWIDTH (AXIS_DWIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata_i  (w_inner_tdata),
        .s_tlast_i  (w_inner_tlast),
        .s_tvalid_i (w_inner_tvalid),
        .s_tready_o (w_inner_tready),
        .m_tdata_o  (m_tdata_o),
        .m_tlast_o  (m_tlast_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i)
    );

endmodule
`default_nettype wire
